// File: rtl/tlb_svx.sv
// Fully associative SvX TLB with superpages, PLRU replacement, duplicate-safe fill and SFENCE.VMA flush.
// Latency: lookup result registered, valid one cycle after lu_valid_i. Backpressure: none, a request is accepted every cycle.
// Optional TLB_PERF_CNT_EN adds saturating hit/miss counters.
package riscv;
  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;
endpackage

module tlb_svx #(
  parameter int unsigned TLB_ENTRIES = 16,
  parameter int unsigned ASID_WIDTH  = 16,
  parameter int unsigned PT_LEVELS   = 3,
  localparam int unsigned VPN_W      = 9 * PT_LEVELS,
  localparam int unsigned VA_W       = 12 + VPN_W,
  localparam int unsigned LVL_W      = $clog2(PT_LEVELS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [ASID_WIDTH-1:0] flush_asid_i,
  input  logic [VA_W-1:0]       flush_vaddr_i,
  input  logic                  upd_valid_i,
  input  logic [VPN_W-1:0]      upd_vpn_i,
  input  logic [LVL_W-1:0]      upd_level_i,
  input  logic [ASID_WIDTH-1:0] upd_asid_i,
  input  riscv::pte_t           upd_content_i,
  input  logic                  lu_valid_i,
  input  logic [ASID_WIDTH-1:0] lu_asid_i,
  input  logic [VA_W-1:0]       lu_vaddr_i,
`ifdef TLB_PERF_CNT_EN
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o,
`endif
  output logic                  lu_valid_o,
  output logic                  lu_hit_o,
  output logic [LVL_W-1:0]      lu_level_o,
  output riscv::pte_t           lu_content_o
);

  localparam int unsigned IDX_W = $clog2(TLB_ENTRIES);

  logic [TLB_ENTRIES-1:0] vld_q;
  logic [VPN_W-1:0]       vpn_q  [TLB_ENTRIES];
  logic [LVL_W-1:0]       lvl_q  [TLB_ENTRIES];
  logic [ASID_WIDTH-1:0]  asid_q [TLB_ENTRIES];
  riscv::pte_t            pte_q  [TLB_ENTRIES];
  logic [TLB_ENTRIES-2:0] plru_q, plru_d;

  logic [TLB_ENTRIES-1:0] lu_match, dup_match, flush_inv;
  logic                   lu_hit, dup_hit, inv_hit, fill_en;
  logic [IDX_W-1:0]       lu_idx, dup_idx, inv_idx, fill_idx, plru_victim;
  logic [VPN_W-1:0]       lu_vpn, flush_vpn;
  logic                   flush_all_asid, flush_all_va;
  logic                   unused_va_lo;

  assign lu_vpn         = lu_vaddr_i[VA_W-1:12];
  assign flush_vpn      = flush_vaddr_i[VA_W-1:12];
  assign flush_all_asid = (flush_asid_i == '0);
  assign flush_all_va   = (flush_vaddr_i == '0);
  assign unused_va_lo   = ^lu_vaddr_i[11:0];
  assign fill_en        = upd_valid_i && !flush_i && (32'(upd_level_i) < PT_LEVELS);

  // Segments below the entry's level are don't-care (superpage offset bits).
  function automatic logic vpn_match(input logic [VPN_W-1:0] a, input logic [VPN_W-1:0] b,
                                     input logic [LVL_W-1:0] lvl);
    logic m;
    m = 1'b1;
    for (int s = 0; s < int'(PT_LEVELS); s++) begin
      if (s >= int'(lvl) && a[9*s +: 9] != b[9*s +: 9]) m = 1'b0;
    end
    return m;
  endfunction

  // Each node bit points at the less recently used half (1 = right).
  function automatic logic [TLB_ENTRIES-2:0] plru_touch(input logic [TLB_ENTRIES-2:0] t,
                                                        input logic [IDX_W-1:0] idx);
    int  node;
    logic b;
    node = 0;
    for (int l = 0; l < int'(IDX_W); l++) begin
      b       = idx[IDX_W-1-l];
      t[node] = ~b;
      node    = 2 * node + 1 + int'(b);
    end
    return t;
  endfunction

  always_comb begin
    lu_match  = '0;
    dup_match = '0;
    flush_inv = '0;
    for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
      lu_match[i]  = vld_q[i] && (asid_q[i] == lu_asid_i || pte_q[i].g) &&
                     vpn_match(vpn_q[i], lu_vpn, lvl_q[i]);
      dup_match[i] = vld_q[i] && asid_q[i] == upd_asid_i && lvl_q[i] == upd_level_i &&
                     vpn_match(vpn_q[i], upd_vpn_i, upd_level_i);
      if (flush_all_asid && flush_all_va)
        flush_inv[i] = 1'b1;
      else if (flush_all_asid)
        flush_inv[i] = vpn_match(vpn_q[i], flush_vpn, lvl_q[i]);
      else if (!flush_all_va)
        flush_inv[i] = vpn_match(vpn_q[i], flush_vpn, lvl_q[i]) &&
                       asid_q[i] == flush_asid_i && !pte_q[i].g;
      else
        flush_inv[i] = asid_q[i] == flush_asid_i && !pte_q[i].g;
    end
  end

  always_comb begin
    lu_hit  = 1'b0;
    lu_idx  = '0;
    dup_hit = 1'b0;
    dup_idx = '0;
    inv_hit = 1'b0;
    inv_idx = '0;
    for (int i = int'(TLB_ENTRIES) - 1; i >= 0; i--) begin
      if (lu_match[i]) begin
        lu_hit = 1'b1;
        lu_idx = IDX_W'(i);
      end
      if (dup_match[i]) begin
        dup_hit = 1'b1;
        dup_idx = IDX_W'(i);
      end
      if (!vld_q[i]) begin
        inv_hit = 1'b1;
        inv_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    int node;
    plru_victim = '0;
    node        = 0;
    for (int l = 0; l < int'(IDX_W); l++) begin
      plru_victim[IDX_W-1-l] = plru_q[node];
      node = 2 * node + 1 + int'(plru_q[node]);
    end
    fill_idx = dup_hit ? dup_idx : (inv_hit ? inv_idx : plru_victim);
  end

  always_comb begin
    plru_d = plru_q;
    if (lu_valid_i && lu_hit) plru_d = plru_touch(plru_d, lu_idx);
    if (fill_en)              plru_d = plru_touch(plru_d, fill_idx);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      plru_q <= '0;
      for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
        vpn_q[i]  <= '0;
        lvl_q[i]  <= '0;
        asid_q[i] <= '0;
        pte_q[i]  <= '0;
      end
    end else begin
      plru_q <= plru_d;
      if (flush_i) begin
        vld_q <= vld_q & ~flush_inv;
      end else if (fill_en) begin
        vld_q[fill_idx]  <= 1'b1;
        vpn_q[fill_idx]  <= upd_vpn_i;
        lvl_q[fill_idx]  <= upd_level_i;
        asid_q[fill_idx] <= upd_asid_i;
        pte_q[fill_idx]  <= upd_content_i;
      end
    end
  end

  // A concurrent flush may kill the entry being looked up, so the result is squashed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lu_valid_o   <= 1'b0;
      lu_hit_o     <= 1'b0;
      lu_level_o   <= '0;
      lu_content_o <= '0;
    end else begin
      lu_valid_o <= lu_valid_i;
      if (lu_valid_i && lu_hit && !flush_i) begin
        lu_hit_o     <= 1'b1;
        lu_level_o   <= lvl_q[lu_idx];
        lu_content_o <= pte_q[lu_idx];
      end else begin
        lu_hit_o     <= 1'b0;
        lu_level_o   <= '0;
        lu_content_o <= '0;
      end
    end
  end

`ifdef TLB_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (lu_valid_o) begin
      if (lu_hit_o) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

  a_single_hit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lu_valid_i |-> $onehot0(lu_match)) else $error("tlb_svx: multiple lookup hits");

  a_upd_level: assert property (@(posedge clk_i) disable iff (!rst_ni)
    upd_valid_i |-> (32'(upd_level_i) < PT_LEVELS)) else $error("tlb_svx: illegal fill level");

endmodule

// File: tb/tb_tlb_svx.sv
// Directed self-checking bench for tlb_svx (4-entry, Sv39 configuration).
module tb_tlb_svx;
  localparam int ENT   = 4;
  localparam int AW    = 16;
  localparam int LV    = 3;
  localparam int VPN_W = 9 * LV;
  localparam int VA_W  = 12 + VPN_W;
  localparam int LVL_W = $clog2(LV);

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              flush_i = 1'b0;
  logic [AW-1:0]     flush_asid_i = '0;
  logic [VA_W-1:0]   flush_vaddr_i = '0;
  logic              upd_valid_i = 1'b0;
  logic [VPN_W-1:0]  upd_vpn_i = '0;
  logic [LVL_W-1:0]  upd_level_i = '0;
  logic [AW-1:0]     upd_asid_i = '0;
  riscv::pte_t       upd_content_i = '0;
  logic              lu_valid_i = 1'b0;
  logic [AW-1:0]     lu_asid_i = '0;
  logic [VA_W-1:0]   lu_vaddr_i = '0;
  logic              lu_valid_o;
  logic              lu_hit_o;
  logic [LVL_W-1:0]  lu_level_o;
  riscv::pte_t       lu_content_o;
`ifdef TLB_PERF_CNT_EN
  logic [31:0]       hit_cnt_o, miss_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  tlb_svx #(.TLB_ENTRIES(ENT), .ASID_WIDTH(AW), .PT_LEVELS(LV)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .flush_i(flush_i), .flush_asid_i(flush_asid_i), .flush_vaddr_i(flush_vaddr_i),
    .upd_valid_i(upd_valid_i), .upd_vpn_i(upd_vpn_i), .upd_level_i(upd_level_i),
    .upd_asid_i(upd_asid_i), .upd_content_i(upd_content_i),
    .lu_valid_i(lu_valid_i), .lu_asid_i(lu_asid_i), .lu_vaddr_i(lu_vaddr_i),
`ifdef TLB_PERF_CNT_EN
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o),
`endif
    .lu_valid_o(lu_valid_o), .lu_hit_o(lu_hit_o), .lu_level_o(lu_level_o),
    .lu_content_o(lu_content_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic riscv::pte_t mk_pte(input logic [43:0] ppn, input logic g);
    riscv::pte_t p;
    p = '0;
    p.ppn = ppn; p.g = g; p.v = 1'b1; p.r = 1'b1; p.w = 1'b1; p.a = 1'b1; p.d = 1'b1;
    return p;
  endfunction

  task automatic fill(input logic [AW-1:0] asid, input logic [VPN_W-1:0] vpn,
                      input logic [LVL_W-1:0] lvl, input riscv::pte_t pte);
    upd_valid_i = 1'b1; upd_asid_i = asid; upd_vpn_i = vpn; upd_level_i = lvl; upd_content_i = pte;
    @(negedge clk_i);
    upd_valid_i = 1'b0;
  endtask

  task automatic flush(input logic [AW-1:0] asid, input logic [VPN_W-1:0] vpn);
    flush_i = 1'b1; flush_asid_i = asid; flush_vaddr_i = {vpn, 12'h000};
    @(negedge clk_i);
    flush_i = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [AW-1:0] asid, input logic [VA_W-1:0] va,
                        input logic exp_hit, input logic [LVL_W-1:0] exp_lvl, input riscv::pte_t exp_pte);
    lu_valid_i = 1'b1; lu_asid_i = asid; lu_vaddr_i = va;
    @(negedge clk_i);
    lu_valid_i = 1'b0;
    check_eq({tag, ".valid"}, 64'(lu_valid_o), 64'd1);
    check_eq({tag, ".hit"},   64'(lu_hit_o),   64'(exp_hit));
    check_eq({tag, ".level"}, 64'(lu_level_o), 64'(exp_lvl));
    check_eq({tag, ".pte"},   64'(lu_content_o), 64'(exp_pte));
  endtask

  function automatic logic [VA_W-1:0] va_of(input logic [VPN_W-1:0] vpn);
    return {vpn, 12'h000};
  endfunction

  riscv::pte_t p0, p1, pa, pb, pc, pc2, pd, pe, pg, ph, pp, pq, pr, pk, pl, pm;

  initial begin
    p0 = mk_pte(44'h1_0123, 1'b0); p1 = mk_pte(44'h2_0400, 1'b0);
    pa = mk_pte(44'hA, 1'b0); pb = mk_pte(44'hB, 1'b0); pc = mk_pte(44'hC, 1'b0);
    pc2 = mk_pte(44'hC2, 1'b0); pd = mk_pte(44'hD, 1'b0); pe = mk_pte(44'hE, 1'b0);
    pg = mk_pte(44'h60, 1'b1); ph = mk_pte(44'h61, 1'b0);
    pp = mk_pte(44'h70, 1'b0); pq = mk_pte(44'h71, 1'b0); pr = mk_pte(44'h72, 1'b1);
    pk = mk_pte(44'h80, 1'b0); pl = mk_pte(44'h81, 1'b0); pm = mk_pte(44'h90, 1'b0);

    // Reset state
    @(negedge clk_i);
    check_eq("rst.valid", 64'(lu_valid_o), 64'd0);
    check_eq("rst.hit",   64'(lu_hit_o),   64'd0);
    check_eq("rst.pte",   64'(lu_content_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_eq("idle.valid", 64'(lu_valid_o), 64'd0);

    // 4 KiB fill, lookup the following cycle
    fill(16'd5, 27'h00123, 2'd0, p0);
    lookup("t4k", 16'd5, va_of(27'h00123), 1'b1, 2'd0, p0);
    lookup("t4k_asid", 16'd6, va_of(27'h00123), 1'b0, 2'd0, '0);

    // 2 MiB superpage
    fill(16'd5, 27'h00400, 2'd1, p1);
    lookup("t2m_in", 16'd5, {27'h005FF, 12'hABC}, 1'b1, 2'd1, p1);
    lookup("t2m_out", 16'd5, va_of(27'h00600), 1'b0, 2'd0, '0);

    // PLRU replacement and duplicate-safe refill
    flush('0, '0);
    lookup("flall", 16'd5, va_of(27'h00123), 1'b0, 2'd0, '0);
    fill(16'd1, 27'h10, 2'd0, pa);
    fill(16'd1, 27'h11, 2'd0, pb);
    fill(16'd1, 27'h12, 2'd0, pc);
    fill(16'd1, 27'h13, 2'd0, pd);
    lookup("touch0", 16'd1, va_of(27'h10), 1'b1, 2'd0, pa);
    lookup("touch2", 16'd1, va_of(27'h12), 1'b1, 2'd0, pc);
    lookup("touch3", 16'd1, va_of(27'h13), 1'b1, 2'd0, pd);
    fill(16'd1, 27'h14, 2'd0, pe);
    lookup("evictB", 16'd1, va_of(27'h11), 1'b0, 2'd0, '0);
    fill(16'd1, 27'h12, 2'd0, pc2);
    lookup("keepA", 16'd1, va_of(27'h10), 1'b1, 2'd0, pa);
    lookup("refillC", 16'd1, va_of(27'h12), 1'b1, 2'd0, pc2);
    lookup("keepD", 16'd1, va_of(27'h13), 1'b1, 2'd0, pd);
    lookup("newE", 16'd1, va_of(27'h14), 1'b1, 2'd0, pe);

    // Global entry vs ASID flush
    flush('0, '0);
    fill(16'd7, 27'h20, 2'd0, pg);
    fill(16'd7, 27'h21, 2'd0, ph);
    lookup("glob_any", 16'd9, va_of(27'h20), 1'b1, 2'd0, pg);
    flush(16'd7, '0);
    lookup("fa7_H", 16'd7, va_of(27'h21), 1'b0, 2'd0, '0);
    lookup("fa7_G", 16'd7, va_of(27'h20), 1'b1, 2'd0, pg);
    flush('0, '0);
    lookup("fall_G", 16'd7, va_of(27'h20), 1'b0, 2'd0, '0);

    // Address-selective flushes
    fill(16'd7, 27'h30, 2'd0, pp);
    fill(16'd7, 27'h31, 2'd0, pq);
    fill(16'd4, 27'h32, 2'd0, pr);
    flush(16'd7, 27'h32);
    flush('0, 27'h30);
    lookup("fva_P", 16'd7, va_of(27'h30), 1'b0, 2'd0, '0);
    lookup("fva_Q", 16'd7, va_of(27'h31), 1'b1, 2'd0, pq);
    lookup("fva_R", 16'd7, va_of(27'h32), 1'b1, 2'd0, pr);
    flush('0, 27'h32);
    lookup("fva0_R", 16'd7, va_of(27'h32), 1'b0, 2'd0, '0);

    // Flush + fill + lookup in one cycle
    flush('0, '0);
    fill(16'd2, 27'h40, 2'd0, pk);
    flush_i = 1'b1; flush_asid_i = '0; flush_vaddr_i = va_of(27'h99);
    upd_valid_i = 1'b1; upd_asid_i = 16'd2; upd_vpn_i = 27'h41; upd_level_i = 2'd0; upd_content_i = pl;
    lu_valid_i = 1'b1; lu_asid_i = 16'd2; lu_vaddr_i = va_of(27'h40);
    @(negedge clk_i);
    flush_i = 1'b0; upd_valid_i = 1'b0; lu_valid_i = 1'b0;
    check_eq("fl_lu.valid", 64'(lu_valid_o), 64'd1);
    check_eq("fl_lu.hit",   64'(lu_hit_o),   64'd0);
    check_eq("fl_lu.pte",   64'(lu_content_o), 64'd0);
    lookup("fl_drop", 16'd2, va_of(27'h41), 1'b0, 2'd0, '0);
    lookup("fl_keep", 16'd2, va_of(27'h40), 1'b1, 2'd0, pk);

    // Fill + lookup in one cycle: lookup does not see the new entry
    upd_valid_i = 1'b1; upd_asid_i = 16'd3; upd_vpn_i = 27'h50; upd_level_i = 2'd0; upd_content_i = pm;
    lu_valid_i = 1'b1; lu_asid_i = 16'd3; lu_vaddr_i = va_of(27'h50);
    @(negedge clk_i);
    upd_valid_i = 1'b0; lu_valid_i = 1'b0;
    check_eq("fill_lu.hit", 64'(lu_hit_o), 64'd0);
    lookup("fill_lu_next", 16'd3, va_of(27'h50), 1'b1, 2'd0, pm);

    // Asynchronous reset with a result in flight
    lu_valid_i = 1'b1; lu_asid_i = 16'd3; lu_vaddr_i = va_of(27'h50);
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("arst.valid", 64'(lu_valid_o), 64'd0);
    check_eq("arst.hit",   64'(lu_hit_o),   64'd0);
    lu_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    lookup("arst_empty", 16'd3, va_of(27'h50), 1'b0, 2'd0, '0);

`ifdef TLB_PERF_CNT_EN
    fill(16'd3, 27'h50, 2'd0, pm);
    lookup("pc_h1", 16'd3, va_of(27'h50), 1'b1, 2'd0, pm);
    lookup("pc_h2", 16'd3, va_of(27'h50), 1'b1, 2'd0, pm);
    lookup("pc_h3", 16'd3, va_of(27'h50), 1'b1, 2'd0, pm);
    lookup("pc_m2", 16'd3, va_of(27'h51), 1'b0, 2'd0, '0);
    @(negedge clk_i);
    check_eq("perf.hit",  64'(hit_cnt_o),  64'd3);
    check_eq("perf.miss", 64'(miss_cnt_o), 64'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
